// File: rtl/memory_access_responder.sv
`default_nettype none
// ============================================================================
//  Module      : memory_access_responder
//  Description : Load/store responder between a core's control FSM and a
//                word-wide synchronous RAM. Forms the effective address,
//                issues RAM read/write strobes and sign/zero-extends loads.
//                Sub-word stores are a read-modify-write pair
//                (STORE_PRELOAD then STORE). Word stores finish in a single
//                cycle. Illegal size codes, misaligned addresses and broken
//                request sequences raise a flag. The block then halts until
//                reset.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock                 in   rising-edge clock
//    reset                 in   asynchronous active-high reset
//    memoryMode[1:0]       in   NOP=00 LOAD=01 STORE_PRELOAD=10 STORE=11
//    funct3[2:0]           in   access size / signedness
//    rs1[31:0]             in   base address
//    rs2[31:0]             in   store data
//    imm[11:0]             in   signed address offset
//    loadData[31:0]        out  extended load result (0 when not valid)
//    loadValid             out  loadData valid this cycle
//    ramAddr[W-1:0]        out  RAM word address
//    ramReadEnable         out  RAM read strobe
//    ramReadData[31:0]     in   RAM data, one cycle after the read strobe
//    ramWriteEnable        out  RAM write strobe
//    ramWriteData[31:0]    out  full word written to RAM
//    memoryUnalignedAccess out  misaligned-access flag
//    memoryBadFunct3       out  illegal funct3 flag
//    sequenceError         out  request sequence violation flag
// ============================================================================
module memory_access_responder #(
    parameter int WORD_ADDR_WIDTH = 12
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [1:0]                 memoryMode,
    input  logic [2:0]                 funct3,
    input  logic [31:0]                rs1,
    input  logic [31:0]                rs2,
    input  logic [11:0]                imm,
    output logic [31:0]                loadData,
    output logic                       loadValid,
    output logic [WORD_ADDR_WIDTH-1:0] ramAddr,
    output logic                       ramReadEnable,
    input  logic [31:0]                ramReadData,
    output logic                       ramWriteEnable,
    output logic [31:0]                ramWriteData,
    output logic                       memoryUnalignedAccess,
    output logic                       memoryBadFunct3,
    output logic                       sequenceError
);

    // ------------------------------------------------------------------
    // Encodings
    // ------------------------------------------------------------------
    localparam logic [1:0] c_MODE_NOP           = 2'b00;
    localparam logic [1:0] c_MODE_LOAD          = 2'b01;
    localparam logic [1:0] c_MODE_STORE_PRELOAD = 2'b10;
    localparam logic [1:0] c_MODE_STORE         = 2'b11;

    localparam logic [1:0] c_ST_IDLE         = 2'd0;
    localparam logic [1:0] c_ST_LOAD_DATA    = 2'd1;
    localparam logic [1:0] c_ST_PRELOAD_HELD = 2'd2;
    localparam logic [1:0] c_ST_HALTED       = 2'd3;

    localparam logic [2:0] c_F3_B  = 3'b000;
    localparam logic [2:0] c_F3_H  = 3'b001;
    localparam logic [2:0] c_F3_W  = 3'b010;
    localparam logic [2:0] c_F3_BU = 3'b100;
    localparam logic [2:0] c_F3_HU = 3'b101;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]  state_q;
    logic [1:0]  state_d;
    logic [31:0] ea_q;        // EA of the first cycle of a two-cycle access
    logic [2:0]  funct3_q;    // funct3 of the first cycle of a two-cycle access
    logic        bad_q;       // flags latched for the HALTED state
    logic        unal_q;
    logic        seq_q;

    // ------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------
    logic [31:0] w_ea;
    logic [4:0]  w_byte_sh;
    logic [4:0]  w_half_sh;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_ext;
    logic [31:0] w_merged;
    logic        w_is_half;
    logic        w_is_word;
    logic        w_bad;
    logic        w_unal;
    logic        w_seq;
    logic        w_fault;

    // Effective address wraps modulo 2^32; only the word-index bits reach the RAM.
    assign w_ea      = rs1 + {{20{imm[11]}}, imm};
    assign w_byte_sh = {w_ea[1:0], 3'b000};
    assign w_half_sh = {w_ea[1], 4'b0000};
    assign w_byte    = ramReadData[w_byte_sh +: 8];
    assign w_half    = ramReadData[w_half_sh +: 16];

    // Load extension: the selected lane of the word returned by the RAM.
    always_comb begin
        w_load_ext = 32'd0;
        case (funct3)
            c_F3_B:  w_load_ext = {{24{w_byte[7]}}, w_byte};
            c_F3_BU: w_load_ext = {24'd0, w_byte};
            c_F3_H:  w_load_ext = {{16{w_half[15]}}, w_half};
            c_F3_HU: w_load_ext = {16'd0, w_half};
            c_F3_W:  w_load_ext = ramReadData;
            default: w_load_ext = 32'd0;
        endcase
    end

    // Sub-word store merge: the preloaded word with one lane replaced.
    always_comb begin
        w_merged = ramReadData;
        if (funct3 == c_F3_B) begin
            w_merged[w_byte_sh +: 8] = rs2[7:0];
        end else begin
            w_merged[w_half_sh +: 16] = rs2[15:0];
        end
    end

    // ------------------------------------------------------------------
    // Fault detection
    // ------------------------------------------------------------------
    always_comb begin
        w_is_half = (funct3 == c_F3_H) || (funct3 == c_F3_HU);
        w_is_word = (funct3 == c_F3_W);

        w_bad = 1'b0;
        case (memoryMode)
            c_MODE_LOAD:
                w_bad = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            c_MODE_STORE_PRELOAD:
                w_bad = (funct3 >= 3'b010);
            // A STORE straight out of IDLE is only legal as a full word;
            // after a preload it carries the sub-word size instead.
            c_MODE_STORE:
                w_bad = (funct3 >= 3'b011) ||
                        ((state_q == c_ST_IDLE) && (funct3 != c_F3_W));
            default:
                w_bad = 1'b0;
        endcase

        w_unal = (memoryMode != c_MODE_NOP) &&
                 ((w_is_half && w_ea[0]) || (w_is_word && (w_ea[1:0] != 2'b00)));

        // The second cycle of an access must repeat the first one's
        // size and address with the matching follow-up mode.
        w_seq = 1'b0;
        case (state_q)
            c_ST_LOAD_DATA:
                w_seq = (memoryMode != c_MODE_LOAD) || (funct3 != funct3_q) || (w_ea != ea_q);
            c_ST_PRELOAD_HELD:
                w_seq = (memoryMode != c_MODE_STORE) || (funct3 != funct3_q) || (w_ea != ea_q);
            default:
                w_seq = 1'b0;
        endcase

        w_fault = (state_q != c_ST_HALTED) && (w_bad || w_unal || w_seq);
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= c_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Access context and flag capture. Flags track the live value until the
    // FSM halts, so HALTED keeps whatever was raised on the way in.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ea_q     <= 32'd0;
            funct3_q <= 3'd0;
            bad_q    <= 1'b0;
            unal_q   <= 1'b0;
            seq_q    <= 1'b0;
        end else begin
            if (state_q == c_ST_IDLE) begin
                ea_q     <= w_ea;
                funct3_q <= funct3;
            end
            if (state_q != c_ST_HALTED) begin
                bad_q  <= w_bad;
                unal_q <= w_unal;
                seq_q  <= w_seq;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE: begin
                if (w_fault) begin
                    state_d = c_ST_HALTED;
                end else if (memoryMode == c_MODE_LOAD) begin
                    state_d = c_ST_LOAD_DATA;
                end else if (memoryMode == c_MODE_STORE_PRELOAD) begin
                    state_d = c_ST_PRELOAD_HELD;
                end else begin
                    state_d = c_ST_IDLE;
                end
            end
            c_ST_LOAD_DATA,
            c_ST_PRELOAD_HELD: begin
                state_d = w_fault ? c_ST_HALTED : c_ST_IDLE;
            end
            default: begin
                state_d = c_ST_HALTED;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        loadData              = 32'd0;
        loadValid             = 1'b0;
        ramAddr               = w_ea[WORD_ADDR_WIDTH+1:2];
        ramReadEnable         = 1'b0;
        ramWriteEnable        = 1'b0;
        ramWriteData          = 32'd0;
        memoryBadFunct3       = w_bad;
        memoryUnalignedAccess = w_unal;
        sequenceError         = w_seq;

        case (state_q)
            c_ST_IDLE: begin
                if (!w_fault) begin
                    case (memoryMode)
                        c_MODE_LOAD,
                        c_MODE_STORE_PRELOAD: ramReadEnable = 1'b1;
                        c_MODE_STORE: begin
                            ramWriteEnable = 1'b1;
                            ramWriteData   = rs2;
                        end
                        default: ;
                    endcase
                end
            end
            c_ST_LOAD_DATA: begin
                if (!w_fault) begin
                    loadValid = 1'b1;
                    loadData  = w_load_ext;
                end
            end
            c_ST_PRELOAD_HELD: begin
                if (!w_fault) begin
                    ramWriteEnable = 1'b1;
                    ramWriteData   = w_merged;
                end
            end
            default: begin
                memoryBadFunct3       = bad_q;
                memoryUnalignedAccess = unal_q;
                sequenceError         = seq_q;
            end
        endcase

        // Reset silences every output at once, independent of the clock.
        if (reset) begin
            loadData              = 32'd0;
            loadValid             = 1'b0;
            ramAddr               = '0;
            ramReadEnable         = 1'b0;
            ramWriteEnable        = 1'b0;
            ramWriteData          = 32'd0;
            memoryBadFunct3       = 1'b0;
            memoryUnalignedAccess = 1'b0;
            sequenceError         = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Interface invariants
    // ------------------------------------------------------------------
    a_strobes_exclusive: assert property (@(posedge clock) disable iff (reset)
        !(ramReadEnable && ramWriteEnable));
    a_load_data_quiet: assert property (@(posedge clock) disable iff (reset)
        loadValid || (loadData == 32'd0));

endmodule
`default_nettype wire

// File: tb/tb_memory_access_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_memory_access_responder
//  Description : Self-checking bench for memory_access_responder. A bench RAM
//                serves the DUT. A shadow word array holds the memory
//                contents as the access rules say they should be. Load
//                results, write words and flag values are derived from that
//                array with plain arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_access_responder;

    localparam int AW = 12;

    logic          clock = 1'b0;
    logic          reset;
    logic [1:0]    memoryMode;
    logic [2:0]    funct3;
    logic [31:0]   rs1, rs2;
    logic [11:0]   imm;
    logic [31:0]   loadData;
    logic          loadValid;
    logic [AW-1:0] ramAddr;
    logic          ramReadEnable;
    logic [31:0]   ramReadData;
    logic          ramWriteEnable;
    logic [31:0]   ramWriteData;
    logic          memoryUnalignedAccess;
    logic          memoryBadFunct3;
    logic          sequenceError;

    memory_access_responder #(.WORD_ADDR_WIDTH(AW)) dut (
        .clock                 (clock),
        .reset                 (reset),
        .memoryMode            (memoryMode),
        .funct3                (funct3),
        .rs1                   (rs1),
        .rs2                   (rs2),
        .imm                   (imm),
        .loadData              (loadData),
        .loadValid             (loadValid),
        .ramAddr               (ramAddr),
        .ramReadEnable         (ramReadEnable),
        .ramReadData           (ramReadData),
        .ramWriteEnable        (ramWriteEnable),
        .ramWriteData          (ramWriteData),
        .memoryUnalignedAccess (memoryUnalignedAccess),
        .memoryBadFunct3       (memoryBadFunct3),
        .sequenceError         (sequenceError)
    );

    always #5 clock = ~clock;

    // Bench RAM: synchronous read, write on the strobe, plus a preset port.
    logic [31:0]   ram    [0:4095];
    logic [31:0]   shadow [0:4095];
    logic          preset_en = 1'b0;
    logic [11:0]   preset_idx = '0;
    logic [31:0]   preset_val = '0;

    always @(posedge clock) begin
        if (preset_en) begin
            ram[preset_idx] <= preset_val;
        end else if (ramWriteEnable) begin
            ram[ramAddr] <= ramWriteData;
        end
        if (ramReadEnable) begin
            ramReadData <= ram[ramAddr];
        end
    end

    int n_vec = 0;
    int n_err = 0;
    int both_strobes = 0;
    int stray_data = 0;

    always @(negedge clock) begin
        if (!reset) begin
            if (ramReadEnable && ramWriteEnable) both_strobes++;
            if (!loadValid && (loadData != 32'd0)) stray_data++;
        end
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- reference rules ----------------
    function automatic logic [31:0] ea_of(input logic [31:0] a, input logic [11:0] im);
        return a + {{20{im[11]}}, im};
    endfunction

    function automatic int widx(input logic [31:0] ea);
        return int'(ea[13:2]);
    endfunction

    function automatic logic [31:0] amask(input logic [2:0] f);
        if (f == 3'd2) return 32'd3;
        if (f == 3'd1 || f == 3'd5) return 32'd1;
        return 32'd0;
    endfunction

    function automatic logic [31:0] ext_load(input logic [31:0] w, input logic [2:0] f, input logic [31:0] ea);
        logic [31:0] v;
        int sh;
        v = 32'd0;
        if (f == 3'd0 || f == 3'd4) begin
            sh = 8 * int'(ea[1:0]);
            v = (w >> sh) & 32'hFF;
            if (f == 3'd0 && v[7]) v = v | 32'hFFFF_FF00;
        end else if (f == 3'd1 || f == 3'd5) begin
            sh = 16 * int'(ea[1]);
            v = (w >> sh) & 32'hFFFF;
            if (f == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
        end else if (f == 3'd2) begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] w, input logic [2:0] f,
                                          input logic [31:0] ea, input logic [31:0] d);
        logic [31:0] m;
        int sh;
        if (f == 3'd0) begin
            sh = 8 * int'(ea[1:0]);
            m = 32'hFF << sh;
        end else begin
            sh = 16 * int'(ea[1]);
            m = 32'hFFFF << sh;
        end
        return (w & ~m) | ((d << sh) & m);
    endfunction

    // {badFunct3, unaligned} for a request seen in a given situation.
    function automatic logic [1:0] rule_flags(input logic [1:0] m, input logic [2:0] f,
                                              input logic [31:0] ea, input bit idle);
        bit bad, unal, half, word;
        half = (f == 3'd1) || (f == 3'd5);
        word = (f == 3'd2);
        bad  = 1'b0;
        if (m == 2'd1 && (f == 3'd3 || f == 3'd6 || f == 3'd7)) bad = 1'b1;
        if (m >= 2'd2 && f >= 3'd3) bad = 1'b1;
        if (m == 2'd2 && f == 3'd2) bad = 1'b1;
        if (m == 2'd3 && idle && f != 3'd2) bad = 1'b1;
        unal = (m != 2'd0) && ((half && ea[0]) || (word && ea[1:0] != 2'd0));
        return {bad, unal};
    endfunction

    // ---------------- drive helpers ----------------
    task automatic set_in(input logic [1:0] m, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] d, input logic [11:0] im);
        memoryMode = m; funct3 = f; rs1 = a; rs2 = d; imm = im;
    endtask

    task automatic to_next();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_cycle(input string tag, input bit rd, input bit wr, input bit lv,
                                input logic [31:0] ld, input logic [31:0] wd, input logic [2:0] fl);
        check_value({tag, ".rd"},    32'(ramReadEnable), 32'(rd));
        check_value({tag, ".wr"},    32'(ramWriteEnable), 32'(wr));
        check_value({tag, ".valid"}, 32'(loadValid), 32'(lv));
        check_value({tag, ".data"},  loadData, ld);
        if (wr) check_value({tag, ".wdata"}, ramWriteData, wd);
        check_value({tag, ".flags"},
                    32'({memoryBadFunct3, memoryUnalignedAccess, sequenceError}), 32'(fl));
    endtask

    task automatic preset(input int i, input logic [31:0] v);
        preset_idx = 12'(i);
        preset_val = v;
        preset_en  = 1'b1;
        to_next();
        preset_en  = 1'b0;
        shadow[i]  = v;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #1;
        expect_cycle("rst", 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'b000);
        check_value("rst.addr", 32'(ramAddr), 32'd0);
        check_value("rst.wdata", ramWriteData, 32'd0);
        to_next();
        reset = 1'b0;
    endtask

    // ---------------- transactions ----------------
    task automatic do_load(input logic [2:0] f, input logic [31:0] a, input logic [11:0] im,
                           input logic [31:0] exp);
        logic [31:0] ea;
        ea = ea_of(a, im);
        set_in(2'd1, f, a, $urandom, im);
        @(negedge clock);
        expect_cycle("ld1", 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 3'b000);
        check_value("ld1.addr", 32'(ramAddr), 32'(widx(ea)));
        to_next();
        @(negedge clock);
        expect_cycle("ld2", 1'b0, 1'b0, 1'b1, exp, 32'd0, 3'b000);
        to_next();
    endtask

    task automatic do_sub_store(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                                input logic [11:0] im, input logic [31:0] exp);
        logic [31:0] ea;
        ea = ea_of(a, im);
        set_in(2'd2, f, a, d, im);
        @(negedge clock);
        expect_cycle("sb1", 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 3'b000);
        to_next();
        set_in(2'd3, f, a, d, im);
        @(negedge clock);
        expect_cycle("sb2", 1'b0, 1'b1, 1'b0, 32'd0, exp, 3'b000);
        check_value("sb2.addr", 32'(ramAddr), 32'(widx(ea)));
        to_next();
        shadow[widx(ea)] = exp;
    endtask

    task automatic do_sw(input logic [31:0] a, input logic [31:0] d, input logic [11:0] im);
        logic [31:0] ea;
        ea = ea_of(a, im);
        set_in(2'd3, 3'd2, a, d, im);
        @(negedge clock);
        expect_cycle("sw", 1'b0, 1'b1, 1'b0, 32'd0, d, 3'b000);
        check_value("sw.addr", 32'(ramAddr), 32'(widx(ea)));
        to_next();
        shadow[widx(ea)] = d;
    endtask

    task automatic do_nop();
        set_in(2'd0, 3'($urandom), $urandom, $urandom, 12'($urandom));
        @(negedge clock);
        expect_cycle("nop", 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'b000);
        to_next();
    endtask

    task automatic hold_and_reset(input logic [2:0] fl);
        set_in(2'd0, 3'd0, 32'd0, 32'd0, 12'd0);
        @(negedge clock);
        expect_cycle("halt.nop", 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, fl);
        to_next();
        set_in(2'd1, 3'd2, 32'h40, 32'd0, 12'd0);
        @(negedge clock);
        expect_cycle("halt.ld", 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, fl);
        to_next();
        apply_reset();
    endtask

    task automatic do_bad_first(input logic [1:0] m, input logic [2:0] f, input logic [31:0] a,
                                input logic [11:0] im);
        logic [31:0] ea;
        logic [2:0]  fl;
        ea = ea_of(a, im);
        fl = {rule_flags(m, f, ea, 1'b1), 1'b0};
        set_in(m, f, a, $urandom, im);
        @(negedge clock);
        expect_cycle("bad1", 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, fl);
        to_next();
        check_value("bad1.ram", ram[widx(ea)], shadow[widx(ea)]);
        hold_and_reset(fl);
    endtask

    task automatic do_seq(input logic [1:0] m1, input logic [2:0] f1, input logic [31:0] a1,
                          input logic [11:0] im1, input logic [1:0] m2, input logic [2:0] f2,
                          input logic [31:0] a2, input logic [11:0] im2);
        logic [2:0] fl;
        int idx;
        idx = widx(ea_of(a1, im1));
        set_in(m1, f1, a1, $urandom, im1);
        @(negedge clock);
        expect_cycle("seq1", 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 3'b000);
        to_next();
        fl = {rule_flags(m2, f2, ea_of(a2, im2), 1'b0), 1'b1};
        set_in(m2, f2, a2, $urandom, im2);
        @(negedge clock);
        expect_cycle("seq2", 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, fl);
        to_next();
        hold_and_reset(fl);
        check_value("seq.ram", ram[idx], shadow[idx]);
    endtask

    task automatic do_reset_mid(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                                input logic [11:0] im);
        int idx;
        idx = widx(ea_of(a, im));
        set_in(2'd2, f, a, d, im);
        @(negedge clock);
        expect_cycle("rm1", 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 3'b000);
        to_next();
        set_in(2'd3, f, a, d, im);
        reset = 1'b1;
        #1;
        expect_cycle("rm.rst", 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'b000);
        check_value("rm.addr", 32'(ramAddr), 32'd0);
        to_next();
        reset = 1'b0;
        check_value("rm.ram", ram[idx], shadow[idx]);
    endtask

    // ---------------- randomized wrappers ----------------
    function automatic logic [2:0] pick_load_f3();
        case ($urandom_range(0, 4))
            0: return 3'd0;
            1: return 3'd1;
            2: return 3'd2;
            3: return 3'd4;
            default: return 3'd5;
        endcase
    endfunction

    task automatic rand_addr(input logic [2:0] f, output logic [31:0] a, output logic [11:0] im);
        im = 12'($urandom);
        a  = $urandom_range(0, 32'h3FFF);
        a  = a - (ea_of(a, im) & amask(f));
    endtask

    task automatic rand_load();
        logic [2:0] f; logic [31:0] a, ea; logic [11:0] im;
        f = pick_load_f3();
        rand_addr(f, a, im);
        ea = ea_of(a, im);
        do_load(f, a, im, ext_load(shadow[widx(ea)], f, ea));
    endtask

    task automatic rand_sub_store();
        logic [2:0] f; logic [31:0] a, ea, d; logic [11:0] im;
        f = 3'($urandom_range(0, 1));
        rand_addr(f, a, im);
        ea = ea_of(a, im);
        d  = $urandom;
        do_sub_store(f, a, d, im, merge(shadow[widx(ea)], f, ea, d));
    endtask

    task automatic rand_sw();
        logic [31:0] a; logic [11:0] im;
        rand_addr(3'd2, a, im);
        do_sw(a, $urandom, im);
    endtask

    task automatic rand_bad();
        logic [1:0] m; logic [2:0] f; logic [31:0] a; logic [11:0] im;
        for (int k = 0; k < 64; k++) begin
            m  = 2'($urandom_range(1, 3));
            f  = 3'($urandom);
            a  = $urandom_range(0, 32'h3FFF);
            im = 12'($urandom);
            if (rule_flags(m, f, ea_of(a, im), 1'b1) != 2'b00) break;
        end
        if (rule_flags(m, f, ea_of(a, im), 1'b1) == 2'b00) begin
            m = 2'd3;
            f = 3'd0;
        end
        do_bad_first(m, f, a, im);
    endtask

    task automatic rand_seq();
        logic [1:0] m1, m2, good; logic [2:0] f, f2; logic [31:0] a; logic [11:0] im, im2;
        m1   = 2'($urandom_range(1, 2));
        f    = (m1 == 2'd1) ? pick_load_f3() : 3'($urandom_range(0, 1));
        rand_addr(f, a, im);
        good = (m1 == 2'd1) ? 2'd1 : 2'd3;
        m2 = good; f2 = f; im2 = im;
        case ($urandom_range(0, 2))
            0: m2 = good + 2'($urandom_range(1, 3));
            1: f2 = f ^ 3'($urandom_range(1, 7));
            default: im2 = im + 12'd4;
        endcase
        do_seq(m1, f, a, im, m2, f2, a, im2);
    endtask

    task automatic rand_reset_mid();
        logic [2:0] f; logic [31:0] a; logic [11:0] im;
        f = 3'($urandom_range(0, 1));
        rand_addr(f, a, im);
        do_reset_mid(f, a, $urandom, im);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset = 1'b1;
        set_in(2'd0, 3'd0, 32'd0, 32'd0, 12'd0);
        for (int i = 0; i < 4096; i++) preset(i, $urandom);
        preset(4, 32'h8070_F0AA);
        expect_cycle("por", 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'b000);
        check_value("por.addr", 32'(ramAddr), 32'd0);
        reset = 1'b0;

        // Byte / half loads from a known word.
        do_load(3'd0, 32'h10, 12'h002, 32'h0000_0070);
        do_load(3'd1, 32'h10, 12'h002, 32'hFFFF_8070);
        do_load(3'd5, 32'h10, 12'h002, 32'h0000_8070);
        do_load(3'd4, 32'h10, 12'h003, 32'h0000_0080);
        do_load(3'd0, 32'h14, 12'hFFC, 32'hFFFF_FFAA);

        // Byte store via read-modify-write, then read the word back.
        set_in(2'd0, 3'd0, 32'd0, 32'd0, 12'd0);
        preset(4, 32'h1122_3344);
        do_sub_store(3'd0, 32'h10, 32'h0000_00AB, 12'h001, 32'h1122_AB44);
        do_load(3'd2, 32'h10, 12'h000, 32'h1122_AB44);

        // Misaligned word store halts with the flag held.
        do_bad_first(2'd3, 3'd2, 32'h10, 12'h006);
        // Illegal funct3 on a load.
        do_bad_first(2'd1, 3'd3, 32'h10, 12'h000);
        // Load abandoned by a NOP in its second cycle.
        do_seq(2'd1, 3'd0, 32'h10, 12'h002, 2'd0, 3'd0, 32'h10, 12'h002);

        // Reset in the middle of a sub-word store, then a clean word store.
        do_reset_mid(3'd0, 32'h20, 32'h0000_005A, 12'h000);
        do_sw(32'h20, 32'hCAFE_F00D, 12'h000);
        do_load(3'd2, 32'h20, 12'h000, 32'hCAFE_F00D);

        for (int it = 0; it < 300; it++) begin
            case ($urandom_range(0, 11))
                0, 1, 2: rand_load();
                3, 4:    rand_sub_store();
                5, 11:   rand_sw();
                6:       do_nop();
                7:       rand_bad();
                8, 9:    rand_seq();
                default: rand_reset_mid();
            endcase
        end

        check_value("strobe_overlap", 32'(both_strobes), 32'd0);
        check_value("loaddata_idle", 32'(stray_data), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached, got no completion expected completion");
        $fatal(1, "simulation time limit");
    end

endmodule
`default_nettype wire

// File: doc/memory_access_responder.md
MEMORY_ACCESS_RESPONDER -- requirements
Module: memory_access_responder

Interface
REQ-001 SHALL have parameter WORD_ADDR_WIDTH, default 12, word-address bits presented to the backing RAM.
REQ-002 SHALL have ports (name, direction, width, meaning):
- clock  in  1  rising-edge clock.
- reset  in  1  reset, asynchronous, active-high.
- memoryMode  in  2  request from control FSM: NOP=00, LOAD=01, STORE_PRELOAD=10, STORE=11.
- funct3  in  3  access size/sign.
- rs1  in  32  base address.
- rs2  in  32  store data.
- imm  in  12  signed offset.
- loadData  out  32  extended load result.
- loadValid  out  1  loadData valid this cycle.
- ramAddr  out  WORD_ADDR_WIDTH  RAM word address.
- ramReadEnable  out  1  RAM read strobe.
- ramReadData  in  32  RAM data, valid one cycle after ramReadEnable.
- ramWriteEnable  out  1  RAM write strobe.
- ramWriteData  out  32  full word to write.
- memoryUnalignedAccess  out  1  misaligned-access flag.
- memoryBadFunct3  out  1  illegal funct3 flag.
- sequenceError  out  1  request sequence violated protocol.

Function
REQ-003 SHALL form effective address EA = rs1 + sign-extended imm, modulo 2^32; ramAddr = EA[WORD_ADDR_WIDTH+1:2]; upper EA bits ignored.
REQ-004 SHALL implement states IDLE, LOAD_DATA, PRELOAD_HELD, HALTED; state registered on rising clock.
REQ-005 IDLE, mode NOP: no RAM strobes, loadValid=0, stay IDLE.
REQ-006 IDLE, mode LOAD, legal: ramReadEnable=1 this cycle; next LOAD_DATA.
REQ-007 LOAD_DATA, mode LOAD: loadValid=1; loadData = selected byte/half/word of ramReadData, sign- (funct3 000/001) or zero-extended (100/101), word for 010; next IDLE.
REQ-008 Byte lane = EA[1:0] for bytes, EA[1] for halves; lane 0 = bits 7:0.
REQ-009 IDLE, mode STORE_PRELOAD, funct3 000/001, legal: ramReadEnable=1; next PRELOAD_HELD.
REQ-010 PRELOAD_HELD, mode STORE: ramWriteEnable=1; ramWriteData = ramReadData with addressed byte/half replaced by rs2[7:0]/rs2[15:0]; next IDLE.
REQ-011 IDLE, mode STORE, funct3 010, legal: ramWriteEnable=1, ramWriteData=rs2 in the same cycle; stay IDLE.
REQ-012 memoryBadFunct3 SHALL assert combinationally when mode LOAD with funct3 in {011,110,111}, or mode STORE_PRELOAD/STORE with funct3 >= 011, or STORE_PRELOAD with 010, or STORE from IDLE with funct3 != 010.
REQ-013 memoryUnalignedAccess SHALL assert combinationally for half access with EA[0]=1 or word access with EA[1:0]!=00, in any non-NOP mode.
REQ-014 Any flag assertion SHALL suppress both RAM strobes that cycle and move to HALTED.
REQ-015 Sequence violation (LOAD_DATA with mode != LOAD, PRELOAD_HELD with mode != STORE, funct3 or EA change between the two cycles of one access) SHALL assert sequenceError, suppress strobes, and move to HALTED.
REQ-016 HALTED SHALL hold all three flags at their latched values, force strobes and loadValid low, and remain until reset.
REQ-017 ramReadEnable and ramWriteEnable SHALL never be high in the same cycle.
REQ-018 loadData SHALL be 0 whenever loadValid=0.

Reset
REQ-019 Reset assertion SHALL immediately force state IDLE, all outputs 0, latched flags 0, regardless of clock.
REQ-020 Reset mid-access (LOAD_DATA or PRELOAD_HELD) SHALL abandon the access with no RAM write; first post-reset cycle is IDLE.

Verification
REQ-021 RAM[4]=0x8070_F0AA; rs1=0x10, imm=0x002, funct3=000, LOAD x2 -> cycle1 ramReadEnable=1, ramAddr=4; cycle2 loadValid=1, loadData=0x0000_0070.
REQ-022 Same RAM, EA=0x12, funct3=001 -> loadData=0xFFFF_8070; funct3=101 -> 0x0000_8070.
REQ-023 RAM[4]=0x1122_3344; rs2=0xAB, funct3=000, EA=0x11; STORE_PRELOAD then STORE -> write cycle ramWriteEnable=1, ramWriteData=0x1122_AB44.
REQ-024 STORE funct3=010, EA=0x16 -> memoryUnalignedAccess=1, no write; flag stays 1 over later NOP cycles until reset.
REQ-025 LOAD then NOP in second cycle -> sequenceError=1, loadValid=0, HALTED.
REQ-026 Reset asserted in PRELOAD_HELD with mode STORE -> no ramWriteEnable pulse; next clean sw succeeds.
